// File: rtl/electronic_scan_clk_gen_if.sv
// Control/status bundle between the read-chain controller and the ADC scan-clock generator.
// The controller side is the master; the generator uses the slave modport.
interface electronic_scan_clk_gen_if #(
    parameter int DIV_W       = 16,
    parameter int RD_WIRE_CNT = 16
);
    localparam int SEL_W = (RD_WIRE_CNT > 1) ? $clog2(RD_WIRE_CNT) : 1;

    logic [DIV_W-1:0] div_half;
    logic             start;
    logic             continuous;
    logic             stop;
    logic             clk_adc;
    logic             adc_cs_n;
    logic             sample_stb;
    logic [SEL_W-1:0] wire_sel;
    logic             conv_done;
    logic             frame_done;
    logic             busy;

    modport master (
        output div_half, start, continuous, stop,
        input  clk_adc, adc_cs_n, sample_stb, wire_sel, conv_done, frame_done, busy
    );

    modport slave (
        input  div_half, start, continuous, stop,
        output clk_adc, adc_cs_n, sample_stb, wire_sel, conv_done, frame_done, busy
    );
endinterface

// File: rtl/electronic_scan_clk_gen.sv
// ADC scan-clock and framing generator: derives clk_adc, chip select, sample strobes and
// the read-wire index from clk_ref, one conversion per wire followed by a quiet gap.
module electronic_scan_clk_gen #(
    parameter int RD_WIRE_CNT = 16,
    parameter int ADC_TQUIET  = 4,
    parameter int GLOBAL_DIV  = 1000,
    parameter int DIV_W       = 16,
    parameter int CONV_BITS   = 16
) (
    input  logic                     clk_ref,
    input  logic                     rst_ref,
    electronic_scan_clk_gen_if.slave bus
);
    localparam int SEL_W  = (RD_WIRE_CNT > 1) ? $clog2(RD_WIRE_CNT) : 1;
    localparam int TC_MAX = (2 * CONV_BITS > 2 * ADC_TQUIET) ? 2 * CONV_BITS : 2 * ADC_TQUIET;
    localparam int TC_W   = $clog2(TC_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(GLOBAL_DIV);

    typedef enum logic [1:0] {IDLE, SETUP, CONV, QUIET} state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [TC_W-1:0]  tcnt_reg, tcnt_next;
    logic             cont_reg, cont_next;
    logic             stop_pend_reg, stop_pend_next;
    logic [SEL_W-1:0] wire_reg, wire_next;
    logic             clk_adc_reg, clk_adc_next;
    logic             cs_n_reg, cs_n_next;
    logic             stb_reg, stb_next;
    logic             conv_done_reg, conv_done_next;
    logic             frame_done_reg, frame_done_next;
    logic             busy_reg, busy_next;

    logic tick;
    logic last_conv;
    logic last_quiet;
    logic last_wire;
    logic frame_loop;

    assign tick       = (div_cnt_reg == div_reg - DIV_ONE);
    assign last_conv  = (tcnt_reg == TC_W'(2 * CONV_BITS - 1));
    assign last_quiet = (tcnt_reg == TC_W'(2 * ADC_TQUIET - 1));
    assign last_wire  = (wire_reg == SEL_W'(RD_WIRE_CNT - 1));
    assign frame_loop = cont_reg && !stop_pend_reg;

    always_ff @(posedge clk_ref) begin
        if (rst_ref) begin
            state_reg      <= IDLE;
            div_reg        <= DIV_RESET;
            div_cnt_reg    <= '0;
            tcnt_reg       <= '0;
            cont_reg       <= 1'b0;
            stop_pend_reg  <= 1'b0;
            wire_reg       <= '0;
            clk_adc_reg    <= 1'b0;
            cs_n_reg       <= 1'b1;
            stb_reg        <= 1'b0;
            conv_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            div_cnt_reg    <= div_cnt_next;
            tcnt_reg       <= tcnt_next;
            cont_reg       <= cont_next;
            stop_pend_reg  <= stop_pend_next;
            wire_reg       <= wire_next;
            clk_adc_reg    <= clk_adc_next;
            cs_n_reg       <= cs_n_next;
            stb_reg        <= stb_next;
            conv_done_reg  <= conv_done_next;
            frame_done_reg <= frame_done_next;
            busy_reg       <= busy_next;
        end
    end

    // Next state plus the bookkeeping that follows it (divider, tick counters, mode latches).
    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        cont_next      = cont_reg;
        stop_pend_next = stop_pend_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next     = SETUP;
                    div_next       = (bus.div_half == '0) ? DIV_ONE : bus.div_half;
                    cont_next      = bus.continuous;
                    stop_pend_next = 1'b0;
                end
            end
            SETUP: begin
                if (tick) state_next = CONV;
            end
            CONV: begin
                if (tick && last_conv) state_next = QUIET;
            end
            QUIET: begin
                if (tick && last_quiet) state_next = (!last_wire || frame_loop) ? SETUP : IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (busy_reg && bus.stop) stop_pend_next = 1'b1;

        // Both counters restart on every state entry so each state owns whole ticks.
        if (state_reg == IDLE || state_next != state_reg) begin
            div_cnt_next = '0;
            tcnt_next    = '0;
        end else if (tick) begin
            div_cnt_next = '0;
            tcnt_next    = tcnt_reg + TC_W'(1);
        end else begin
            div_cnt_next = div_cnt_reg + DIV_ONE;
            tcnt_next    = tcnt_reg;
        end
    end

    always_comb begin
        clk_adc_next    = clk_adc_reg;
        cs_n_next       = cs_n_reg;
        stb_next        = 1'b0;
        conv_done_next  = 1'b0;
        frame_done_next = 1'b0;
        busy_next       = busy_reg;
        wire_next       = wire_reg;
        case (state_reg)
            IDLE: begin
                clk_adc_next = 1'b0;
                if (bus.start) begin
                    cs_n_next = 1'b0;
                    busy_next = 1'b1;
                    wire_next = '0;
                end
            end
            SETUP: begin
                clk_adc_next = 1'b0;
                cs_n_next    = 1'b0;
                if (tick) begin
                    clk_adc_next = 1'b1;
                    stb_next     = 1'b1;
                end
            end
            CONV: begin
                // Even tick index: falling edge; odd: next bit's rising edge; final: close out.
                if (tick) begin
                    if (last_conv) begin
                        clk_adc_next   = 1'b0;
                        cs_n_next      = 1'b1;
                        conv_done_next = 1'b1;
                    end else if (!tcnt_reg[0]) begin
                        clk_adc_next = 1'b0;
                    end else begin
                        clk_adc_next = 1'b1;
                        stb_next     = 1'b1;
                    end
                end
            end
            QUIET: begin
                clk_adc_next = 1'b0;
                cs_n_next    = 1'b1;
                if (tick && last_quiet) begin
                    if (!last_wire) begin
                        wire_next = wire_reg + SEL_W'(1);
                        cs_n_next = 1'b0;
                    end else begin
                        wire_next       = '0;
                        frame_done_next = 1'b1;
                        if (frame_loop) cs_n_next = 1'b0;
                        else            busy_next = 1'b0;
                    end
                end
            end
            default: begin
                clk_adc_next = 1'b0;
                cs_n_next    = 1'b1;
                busy_next    = 1'b0;
            end
        endcase
    end

    assign bus.clk_adc    = clk_adc_reg;
    assign bus.adc_cs_n   = cs_n_reg;
    assign bus.sample_stb = stb_reg;
    assign bus.wire_sel   = wire_reg;
    assign bus.conv_done  = conv_done_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.busy       = busy_reg;
endmodule
